// File: rtl/pending_encoder.sv
// rtl/pending_encoder.sv - accumulating request encoder that hands out one index per handshake
// Priority is fixed-LSB, fixed-MSB or round-robin depending on MODE.
module pending_encoder #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH),
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDXW-1:0]  out_idx,
    output logic [WIDTH-1:0] pending,
    output logic [IDXW:0]    pend_cnt,
    output logic             overflow
);

    localparam int CW = IDXW + 1;

    logic [WIDTH-1:0] pending_q, pending_d;
    logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;
    logic             overflow_q, overflow_d;
    logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             slot_free;
    logic             found;
    logic             grant;
    logic [IDXW-1:0]  g;
    logic [WIDTH-1:0] grant_oh;

    function automatic logic [IDXW-1:0] rr_pos(input logic [IDXW-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= WIDTH) s = s - WIDTH;
        return IDXW'(s);
    endfunction

    // Later loop iterations overwrite earlier ones, so scan order sets priority.
    always_comb begin
        found = 1'b0;
        g     = '0;
        if (MODE == 0) begin
            for (int k = WIDTH - 1; k >= 0; k--) begin
                if (pending_q[k]) begin
                    found = 1'b1;
                    g     = IDXW'(k);
                end
            end
        end else if (MODE == 1) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (pending_q[k]) begin
                    found = 1'b1;
                    g     = IDXW'(k);
                end
            end
        end else begin
            for (int k = WIDTH - 1; k >= 0; k--) begin
                if (pending_q[rr_pos(rr_ptr_q, k)]) begin
                    found = 1'b1;
                    g     = rr_pos(rr_ptr_q, k);
                end
            end
        end
    end

    always_comb begin
        slot_free   = !out_valid_q || out_ready;
        grant       = slot_free && found;
        grant_oh    = '0;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant) begin
            grant_oh[g] = 1'b1;
            out_idx_d   = g;
            rr_ptr_d    = (int'(g) == WIDTH - 1) ? '0 : IDXW'(int'(g) + 1);
        end
        if (slot_free) begin
            out_valid_d = found;
        end
        // A request landing on the bit being granted keeps it pending (set wins).
        pending_d  = (pending_q & ~grant_oh) | req;
        overflow_d = overflow_q | (|(req & pending_q & ~grant_oh));
        pend_cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pend_cnt_d = pend_cnt_d + CW'(pending_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            pend_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            overflow_q  <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            pend_cnt_q  <= pend_cnt_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            overflow_q  <= overflow_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign pend_cnt  = pend_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pending_encoder.sv
// tb/tb_pending_encoder.sv - directed bench for pending_encoder
// Four instances: WIDTH 8 in MODE 0/1/2 and WIDTH 5 in MODE 0.
module tb_pending_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] req0, req1, req2;
    logic [4:0] req5;
    logic       rdy0, rdy1, rdy2, rdy5;
    logic       v0, v1, v2, v5;
    logic [2:0] i0, i1, i2, i5;
    logic [7:0] p0, p1, p2;
    logic [4:0] p5;
    logic [3:0] c0, c1, c2, c5;
    logic       o0, o1, o2, o5;

    pending_encoder #(.WIDTH(8), .MODE(0)) u0 (.clk(clk), .rst(rst), .req(req0), .out_ready(rdy0),
        .out_valid(v0), .out_idx(i0), .pending(p0), .pend_cnt(c0), .overflow(o0));
    pending_encoder #(.WIDTH(8), .MODE(1)) u1 (.clk(clk), .rst(rst), .req(req1), .out_ready(rdy1),
        .out_valid(v1), .out_idx(i1), .pending(p1), .pend_cnt(c1), .overflow(o1));
    pending_encoder #(.WIDTH(8), .MODE(2)) u2 (.clk(clk), .rst(rst), .req(req2), .out_ready(rdy2),
        .out_valid(v2), .out_idx(i2), .pending(p2), .pend_cnt(c2), .overflow(o2));
    pending_encoder #(.WIDTH(5), .MODE(0)) u5 (.clk(clk), .rst(rst), .req(req5), .out_ready(rdy5),
        .out_valid(v5), .out_idx(i5), .pending(p5), .pend_cnt(c5), .overflow(o5));

    typedef struct packed {
        logic [7:0] req;
        logic       rdy;
        logic       valid;
        logic [2:0] idx;
        logic [7:0] pend;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tbl [21];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " u0 out"}, {27'd0, v0, i0, o0}, 32'd0);
        chk({tag, " u0 pend"}, {20'd0, p0, c0}, 32'd0);
        chk({tag, " u1 out"}, {20'd0, v1, i1, o1, p1}, 32'd0);
        chk({tag, " u2 out"}, {20'd0, v2, i2, o2, p2}, 32'd0);
        chk({tag, " u5 out"}, {23'd0, v5, i5, o5, p5}, 32'd0);
        chk({tag, " cnts"}, {20'd0, c1, c2, c5}, 32'd0);
    endtask

    initial begin
        // req, rdy | valid, idx, pending, cnt, ovf after the edge
        tbl[0]  = {8'h10, 1'b1, 1'b0, 3'd0, 8'h10, 4'd1, 1'b0};
        tbl[1]  = {8'h00, 1'b1, 1'b1, 3'd4, 8'h00, 4'd0, 1'b0};
        tbl[2]  = {8'h00, 1'b1, 1'b0, 3'd4, 8'h00, 4'd0, 1'b0};
        tbl[3]  = {8'h06, 1'b0, 1'b0, 3'd4, 8'h06, 4'd2, 1'b0};
        tbl[4]  = {8'h00, 1'b0, 1'b1, 3'd1, 8'h04, 4'd1, 1'b0};
        tbl[5]  = {8'h00, 1'b0, 1'b1, 3'd1, 8'h04, 4'd1, 1'b0};
        tbl[6]  = {8'h00, 1'b0, 1'b1, 3'd1, 8'h04, 4'd1, 1'b0};
        tbl[7]  = {8'h00, 1'b0, 1'b1, 3'd1, 8'h04, 4'd1, 1'b0};
        tbl[8]  = {8'h00, 1'b0, 1'b1, 3'd1, 8'h04, 4'd1, 1'b0};
        tbl[9]  = {8'h00, 1'b0, 1'b1, 3'd1, 8'h04, 4'd1, 1'b0};
        tbl[10] = {8'h00, 1'b1, 1'b1, 3'd2, 8'h00, 4'd0, 1'b0};
        tbl[11] = {8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 4'd0, 1'b0};
        tbl[12] = {8'h20, 1'b1, 1'b0, 3'd2, 8'h20, 4'd1, 1'b0};
        tbl[13] = {8'h20, 1'b1, 1'b1, 3'd5, 8'h20, 4'd1, 1'b0};
        tbl[14] = {8'h00, 1'b1, 1'b1, 3'd5, 8'h00, 4'd0, 1'b0};
        tbl[15] = {8'h00, 1'b1, 1'b0, 3'd5, 8'h00, 4'd0, 1'b0};
        tbl[16] = {8'h01, 1'b0, 1'b0, 3'd5, 8'h01, 4'd1, 1'b0};
        tbl[17] = {8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 4'd1, 1'b0};
        tbl[18] = {8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 4'd1, 1'b1};
        tbl[19] = {8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 4'd0, 1'b1};
        tbl[20] = {8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b1};

        req0 = '0; req1 = '0; req2 = '0; req5 = '0;
        rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0; rdy5 = 1'b0;
        #12;
        chk_all_zero("reset");
        rst = 1'b0;

        for (int n = 0; n < 21; n++) begin
            req0 = tbl[n].req;
            rdy0 = tbl[n].rdy;
            step();
            chk($sformatf("tbl%0d valid", n), 32'(v0), 32'(tbl[n].valid));
            chk($sformatf("tbl%0d idx", n), 32'(i0), 32'(tbl[n].idx));
            chk($sformatf("tbl%0d pending", n), 32'(p0), 32'(tbl[n].pend));
            chk($sformatf("tbl%0d pend_cnt", n), 32'(c0), 32'(tbl[n].cnt));
            chk($sformatf("tbl%0d overflow", n), 32'(o0), 32'(tbl[n].ovf));
        end
        req0 = '0;
        rdy0 = 1'b0;

        // Lowest-first vs highest-first on the same two-bit request.
        req0 = 8'h81; req1 = 8'h81; rdy0 = 1'b1; rdy1 = 1'b1;
        step();
        req0 = '0; req1 = '0;
        chk("m01 pend0", 32'(p0), 32'h81);
        chk("m01 pend1", 32'({c1, p1}), 32'h281);
        step();
        chk("m0 first", 32'({v0, i0}), 32'({1'b1, 3'd0}));
        chk("m1 first", 32'({v1, i1}), 32'({1'b1, 3'd7}));
        step();
        chk("m0 second", 32'({v0, i0}), 32'({1'b1, 3'd7}));
        chk("m1 second", 32'({v1, i1}), 32'({1'b1, 3'd0}));
        step();
        chk("m01 drained", 32'({v0, v1, p0, p1}), 32'd0);
        rdy0 = 1'b0; rdy1 = 1'b0;

        // Round-robin with a continuously held request.
        req2 = 8'h89; rdy2 = 1'b1;
        step();
        chk("rr cyc1 valid", 32'(v2), 32'd0);
        chk("rr cyc1 ovf", 32'(o2), 32'd0);
        step();
        chk("rr cyc2 ovf", 32'(o2), 32'd1);
        for (int n = 0; n < 6; n++) begin
            logic [2:0] exp_idx;
            exp_idx = (n % 3 == 0) ? 3'd0 : (n % 3 == 1) ? 3'd3 : 3'd7;
            chk($sformatf("rr grant%0d", n), 32'({v2, i2}), 32'({1'b1, exp_idx}));
            chk($sformatf("rr pend%0d", n), 32'(p2), 32'h89);
            step();
        end
        req2 = '0; rdy2 = 1'b0;

        // Non-power-of-2 width drains all five lines in order.
        req5 = 5'h1F; rdy5 = 1'b1;
        step();
        req5 = '0;
        chk("w5 cnt load", 32'({v5, c5, p5}), 32'({1'b0, 4'd5, 5'h1F}));
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("w5 idx%0d", n), 32'({v5, i5}), 32'({1'b1, 3'(n)}));
            chk($sformatf("w5 cnt%0d", n), 32'(c5), 32'(4 - n));
        end
        step();
        chk("w5 drained", 32'({v5, o5, p5}), 32'd0);
        rdy5 = 1'b0;

        // Asynchronous reset while busy.
        req0 = 8'hA5; rdy0 = 1'b0;
        step();
        step();
        req0 = '0;
        chk("pre-rst pending", 32'(p0), 32'hA5);
        chk("pre-rst valid", 32'(v0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async rst");
        #2;
        rst = 1'b0;
        step();
        chk("post-rst idle", 32'({v0, p0, o0}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
